// File: rtl/pll_lock_supervisor_if.sv
// Signal bundle between the PLL lock supervisor and its surroundings.
// The slave modport is the supervisor's view. The master modport is the system's view.
interface pll_lock_supervisor_if;
    logic       pll_lock;
    logic       force_relock;
    logic       pll_reset;
    logic       usb_rst_n;
    logic       locked;
    logic       fail;
    logic [2:0] retry_cnt;
    logic [7:0] lock_loss_cnt;

    modport master (
        output pll_lock, force_relock,
        input  pll_reset, usb_rst_n, locked, fail, retry_cnt, lock_loss_cnt
    );

    modport slave (
        input  pll_lock, force_relock,
        output pll_reset, usb_rst_n, locked, fail, retry_cnt, lock_loss_cnt
    );
endinterface

// File: rtl/pll_lock_supervisor.sv
// Sequences the PLL reset, debounces lock and gates the downstream USB/UVC reset.
// After repeated lock timeouts it parks in a sticky FAIL state.
module pll_lock_supervisor #(
    parameter int unsigned RST_PULSE_CYCLES    = 24,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 24000,
    parameter int unsigned LOCK_STABLE_CYCLES  = 2400,
    parameter int unsigned MAX_RETRIES         = 7
) (
    input  logic                    clk,
    input  logic                    rst_n,
    pll_lock_supervisor_if.slave    bus
);
    localparam int unsigned MAX_AB = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                                     RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int unsigned MAX_P  = (MAX_AB > LOCK_STABLE_CYCLES) ? MAX_AB : LOCK_STABLE_CYCLES;
    localparam int unsigned CNT_W  = (MAX_P > 1) ? $clog2(MAX_P) : 1;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [2:0]       RETRY_LIMIT  = 3'(MAX_RETRIES);

    typedef enum logic [2:0] {
        RESET_PLL,
        WAIT_LOCK,
        STABILIZE,
        RUN,
        FAIL
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       lock_sync;
    logic             lock_s;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lock_sync <= 2'b00;
        else        lock_sync <= {lock_sync[0], bus.pll_lock};
    end

    assign lock_s = lock_sync[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= RESET_PLL;
            cnt               <= '0;
            bus.pll_reset     <= 1'b1;
            bus.usb_rst_n     <= 1'b0;
            bus.locked        <= 1'b0;
            bus.fail          <= 1'b0;
            bus.retry_cnt     <= 3'd0;
            bus.lock_loss_cnt <= 8'd0;
        end else begin
            cnt <= cnt + CNT_W'(1);
            unique case (state)
                RESET_PLL: begin
                    if (bus.force_relock) begin
                        cnt <= '0;
                    end else if (cnt == RST_LAST) begin
                        state         <= WAIT_LOCK;
                        cnt           <= '0;
                        bus.pll_reset <= 1'b0;
                    end
                end
                WAIT_LOCK: begin
                    if (bus.force_relock) begin
                        state         <= RESET_PLL;
                        cnt           <= '0;
                        bus.pll_reset <= 1'b1;
                    end else if (lock_s) begin
                        state <= STABILIZE;
                        cnt   <= '0;
                    end else if (cnt == TIMEOUT_LAST) begin
                        cnt <= '0;
                        if (bus.retry_cnt == RETRY_LIMIT) begin
                            state    <= FAIL;
                            bus.fail <= 1'b1;
                        end else begin
                            state         <= RESET_PLL;
                            bus.pll_reset <= 1'b1;
                            bus.retry_cnt <= bus.retry_cnt + 3'd1;
                        end
                    end
                end
                STABILIZE: begin
                    if (bus.force_relock) begin
                        state         <= RESET_PLL;
                        cnt           <= '0;
                        bus.pll_reset <= 1'b1;
                    end else if (!lock_s) begin
                        // Back to WAIT_LOCK with a fresh timeout; this is not a retry.
                        state <= WAIT_LOCK;
                        cnt   <= '0;
                    end else if (cnt == STABLE_LAST) begin
                        state         <= RUN;
                        cnt           <= '0;
                        bus.locked    <= 1'b1;
                        bus.usb_rst_n <= 1'b1;
                        bus.retry_cnt <= 3'd0;
                    end
                end
                RUN: begin
                    if (!lock_s || bus.force_relock) begin
                        state         <= RESET_PLL;
                        cnt           <= '0;
                        bus.pll_reset <= 1'b1;
                        bus.locked    <= 1'b0;
                        bus.usb_rst_n <= 1'b0;
                        if (!lock_s && bus.lock_loss_cnt != 8'hFF)
                            bus.lock_loss_cnt <= bus.lock_loss_cnt + 8'd1;
                    end
                end
                FAIL: begin
                    if (bus.force_relock) begin
                        state         <= RESET_PLL;
                        cnt           <= '0;
                        bus.pll_reset <= 1'b1;
                        bus.fail      <= 1'b0;
                        bus.retry_cnt <= 3'd0;
                    end
                end
                default: begin
                    state         <= RESET_PLL;
                    cnt           <= '0;
                    bus.pll_reset <= 1'b1;
                    bus.locked    <= 1'b0;
                    bus.usb_rst_n <= 1'b0;
                    bus.fail      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with RST=4, TIMEOUT=32, STABLE=8, MAX_RETRIES=2.
// Expected cycle counts are hand-derived from the two-flop lock synchronizer latency.
module tb_pll_lock_supervisor;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   cyc   = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    pll_lock_supervisor_if bus ();

    pll_lock_supervisor #(
        .RST_PULSE_CYCLES   (4),
        .LOCK_TIMEOUT_CYCLES(32),
        .LOCK_STABLE_CYCLES (8),
        .MAX_RETRIES        (2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset(input logic lock_val);
        rst_n = 1'b0;
        bus.force_relock = 1'b0;
        bus.pll_lock = lock_val;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_locked(input string tag);
        for (int i = 0; i < 80 && !bus.locked; i++) @(negedge clk);
        n_checks++;
        if (bus.locked !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_wait_locked: locked=%b expected 1 within 80 cycles", tag, bus.locked);
        end
    endtask

    task automatic check_reset_values(input string tag);
        n_checks++; if (bus.pll_reset !== 1'b1) begin n_fail++; $display("FAIL %s_pll_reset: got %b exp 1", tag, bus.pll_reset); end
        n_checks++; if (bus.usb_rst_n !== 1'b0) begin n_fail++; $display("FAIL %s_usb_rst_n: got %b exp 0", tag, bus.usb_rst_n); end
        n_checks++; if (bus.locked !== 1'b0) begin n_fail++; $display("FAIL %s_locked: got %b exp 0", tag, bus.locked); end
        n_checks++; if (bus.fail !== 1'b0) begin n_fail++; $display("FAIL %s_fail: got %b exp 0", tag, bus.fail); end
        n_checks++; if (bus.retry_cnt !== 3'd0) begin n_fail++; $display("FAIL %s_retry_cnt: got %0d exp 0", tag, bus.retry_cnt); end
        n_checks++; if (bus.lock_loss_cnt !== 8'd0) begin n_fail++; $display("FAIL %s_lock_loss_cnt: got %0d exp 0", tag, bus.lock_loss_cnt); end
    endtask

    task automatic test_reset();
        bus.pll_lock = 1'b0;
        bus.force_relock = 1'b0;
        #1 rst_n = 1'b0;
        #1 check_reset_values("reset");
    endtask

    task automatic test_lock_up();
        int hi = 0;
        int e;
        do_reset(1'b0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.pll_reset) hi++;
            else break;
        end
        n_checks++; if (hi != 4) begin n_fail++; $display("FAIL t1_pulse_width: got %0d cycles exp 4", hi); end
        repeat (5) @(negedge clk);
        bus.pll_lock = 1'b1;
        e = cyc + 1;
        for (int i = 0; i < 40 && !bus.locked; i++) @(negedge clk);
        n_checks++; if (bus.locked !== 1'b1 || cyc - e != 10) begin n_fail++; $display("FAIL t1_lock_latency: locked=%b after %0d edges exp 1 after 10", bus.locked, cyc - e); end
        n_checks++; if (bus.usb_rst_n !== 1'b1) begin n_fail++; $display("FAIL t1_usb_rst_n: got %b exp 1", bus.usb_rst_n); end
        n_checks++; if (bus.retry_cnt !== 3'd0) begin n_fail++; $display("FAIL t1_retry_cnt: got %0d exp 0", bus.retry_cnt); end
        n_checks++; if (bus.pll_reset !== 1'b0) begin n_fail++; $display("FAIL t1_pll_reset_run: got %b exp 0", bus.pll_reset); end
    endtask

    task automatic test_retry_fail();
        int   entries = 0;
        int   t_entry = 0;
        int   hi_len  = 0;
        int   hi      = 1;
        logic prev_pr = 1'b1;
        logic [2:0] retry_at [3];
        int         len_at   [3];
        do_reset(1'b0);
        for (int i = 0; i < 400 && !bus.fail; i++) begin
            @(negedge clk);
            if (bus.pll_reset) hi_len++;
            else if (prev_pr) begin
                if (entries < 3) begin
                    retry_at[entries] = bus.retry_cnt;
                    len_at[entries]   = hi_len;
                end
                entries++;
                t_entry = cyc;
                hi_len  = 0;
            end
            prev_pr = bus.pll_reset;
        end
        n_checks++; if (entries != 3) begin n_fail++; $display("FAIL t2_wait_entries: got %0d exp 3", entries); end
        for (int k = 0; k < 3 && k < entries; k++) begin
            n_checks++; if (retry_at[k] !== 3'(k)) begin n_fail++; $display("FAIL t2_retry_step%0d: got %0d exp %0d", k, retry_at[k], k); end
            n_checks++; if (len_at[k] != 4) begin n_fail++; $display("FAIL t2_pulse%0d_width: got %0d exp 4", k, len_at[k]); end
        end
        n_checks++; if (bus.fail !== 1'b1 || cyc - t_entry != 32) begin n_fail++; $display("FAIL t2_fail_timing: fail=%b after %0d cycles exp 1 after 32", bus.fail, cyc - t_entry); end
        n_checks++; if (bus.pll_reset !== 1'b0 || bus.usb_rst_n !== 1'b0) begin n_fail++; $display("FAIL t2_fail_outputs: pll_reset=%b usb_rst_n=%b exp 0 0", bus.pll_reset, bus.usb_rst_n); end
        bus.pll_lock = 1'b1;
        repeat (6) @(negedge clk);
        n_checks++; if (bus.fail !== 1'b1 || bus.locked !== 1'b0) begin n_fail++; $display("FAIL t2_fail_ignores_lock: fail=%b locked=%b exp 1 0", bus.fail, bus.locked); end
        bus.pll_lock = 1'b0;
        bus.force_relock = 1'b1;
        @(negedge clk);
        bus.force_relock = 1'b0;
        n_checks++; if (bus.fail !== 1'b0 || bus.retry_cnt !== 3'd0) begin n_fail++; $display("FAIL t2_relock_clear: fail=%b retry_cnt=%0d exp 0 0", bus.fail, bus.retry_cnt); end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.pll_reset) hi++;
            else break;
        end
        n_checks++; if (hi != 4) begin n_fail++; $display("FAIL t2_relock_pulse: got %0d cycles exp 4", hi); end
    endtask

    task automatic test_stabilize_drop();
        int   e;
        int   t_lock = -1;
        logic retry_mid = 1'b0;
        logic saw_reset = 1'b0;
        do_reset(1'b0);
        for (int i = 0; i < 20 && bus.pll_reset; i++) @(negedge clk);
        for (int i = 0; i < 40 && !bus.pll_reset; i++) @(negedge clk);
        for (int i = 0; i < 20 && bus.pll_reset; i++) @(negedge clk);
        n_checks++; if (bus.retry_cnt !== 3'd1 || bus.pll_reset !== 1'b0) begin n_fail++; $display("FAIL t3_setup: retry_cnt=%0d pll_reset=%b exp 1 0", bus.retry_cnt, bus.pll_reset); end
        bus.pll_lock = 1'b1;
        e = cyc + 1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (cyc == e + 5) bus.pll_lock = 1'b0;
            if (cyc == e + 8) bus.pll_lock = 1'b1;
            if (cyc == e + 18) retry_mid = (bus.retry_cnt == 3'd1);
            if (bus.pll_reset) saw_reset = 1'b1;
            if (bus.locked) begin
                t_lock = cyc;
                break;
            end
        end
        n_checks++; if (t_lock != e + 19) begin n_fail++; $display("FAIL t3_relock_time: locked at %0d edges exp 19", t_lock - e); end
        n_checks++; if (retry_mid !== 1'b1) begin n_fail++; $display("FAIL t3_retry_kept: got 0 exp retry_cnt 1 before RUN"); end
        n_checks++; if (saw_reset !== 1'b0) begin n_fail++; $display("FAIL t3_no_resequence: pll_reset pulsed, exp none"); end
        n_checks++; if (bus.retry_cnt !== 3'd0) begin n_fail++; $display("FAIL t3_retry_clear: got %0d exp 0", bus.retry_cnt); end
    endtask

    task automatic test_lock_loss_sat();
        do_reset(1'b1);
        for (int n = 1; n <= 300; n++) begin
            for (int i = 0; i < 60 && !bus.locked; i++) @(negedge clk);
            n_checks++;
            if (bus.locked !== 1'b1) begin
                n_fail++;
                $display("FAIL t4_relock%0d: locked=%b exp 1", n, bus.locked);
                break;
            end
            bus.pll_lock = 1'b0;
            @(negedge clk);
            @(negedge clk);
            n_checks++; if (bus.usb_rst_n !== 1'b1) begin n_fail++; $display("FAIL t4_early_drop%0d: usb_rst_n=%b at E+1 exp 1", n, bus.usb_rst_n); end
            @(negedge clk);
            n_checks++; if (bus.usb_rst_n !== 1'b0 || bus.locked !== 1'b0 || bus.pll_reset !== 1'b1) begin n_fail++; $display("FAIL t4_drop%0d: usb_rst_n=%b locked=%b pll_reset=%b exp 0 0 1", n, bus.usb_rst_n, bus.locked, bus.pll_reset); end
            if (n == 1 || n == 255) begin
                n_checks++; if (bus.lock_loss_cnt !== 8'(n)) begin n_fail++; $display("FAIL t4_count%0d: got %0d exp %0d", n, bus.lock_loss_cnt, n); end
            end
            bus.pll_lock = 1'b1;
        end
        n_checks++; if (bus.lock_loss_cnt !== 8'd255) begin n_fail++; $display("FAIL t4_saturate: got %0d exp 255", bus.lock_loss_cnt); end
    endtask

    task automatic test_force_relock_run();
        do_reset(1'b1);
        wait_locked("t5a");
        bus.pll_lock = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus.force_relock = 1'b1;
        @(negedge clk);
        bus.force_relock = 1'b0;
        n_checks++; if (bus.lock_loss_cnt !== 8'd1) begin n_fail++; $display("FAIL t5_same_cycle_count: got %0d exp 1", bus.lock_loss_cnt); end
        n_checks++; if (bus.usb_rst_n !== 1'b0 || bus.pll_reset !== 1'b1) begin n_fail++; $display("FAIL t5_same_cycle_out: usb_rst_n=%b pll_reset=%b exp 0 1", bus.usb_rst_n, bus.pll_reset); end
        bus.pll_lock = 1'b1;
        wait_locked("t5b");
        bus.force_relock = 1'b1;
        @(negedge clk);
        bus.force_relock = 1'b0;
        n_checks++; if (bus.usb_rst_n !== 1'b0 || bus.locked !== 1'b0 || bus.pll_reset !== 1'b1) begin n_fail++; $display("FAIL t5_force_alone: usb_rst_n=%b locked=%b pll_reset=%b exp 0 0 1", bus.usb_rst_n, bus.locked, bus.pll_reset); end
        n_checks++; if (bus.lock_loss_cnt !== 8'd1) begin n_fail++; $display("FAIL t5_force_count: got %0d exp 1", bus.lock_loss_cnt); end
    endtask

    task automatic test_async_reset();
        do_reset(1'b1);
        for (int i = 0; i < 20 && bus.pll_reset; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        n_checks++; if (bus.pll_reset !== 1'b0 || bus.locked !== 1'b0) begin n_fail++; $display("FAIL t6_in_stabilize: pll_reset=%b locked=%b exp 0 0", bus.pll_reset, bus.locked); end
        #2 rst_n = 1'b0;
        #1 check_reset_values("t6_stab");
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_locked("t6");
        bus.pll_lock = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (bus.pll_reset !== 1'b1 || bus.lock_loss_cnt !== 8'd1) begin n_fail++; $display("FAIL t6_in_reset_pll: pll_reset=%b lock_loss_cnt=%0d exp 1 1", bus.pll_reset, bus.lock_loss_cnt); end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_values("t6_rstpll");
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_lock_up();
        test_retry_fail();
        test_stabilize_drop();
        test_lock_loss_sat();
        test_force_relock_run();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
